// File: rtl/kp_midi_ctrl.sv
// MIDI note-on/off parser driving Karplus-Strong trig/velocity/delay_length; KP_MIDI_OMNI_EN accepts all channels.
// Latency: LOAD one cycle after the D2 strobe, outputs update at end of LOAD, trig falls one cycle later.
// No backpressure: events during a pulse go to a one-deep pending slot, newest wins.
module kp_midi_ctrl #(
  parameter int TRIG_HOLD = 8,
  parameter int MIN_DELAY = 2
) (
  input  logic        a_clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  input  logic [3:0]  midi_chan,
  output logic        trig,
  output logic [6:0]  velocity,
  output logic [11:0] delay_length,
  output logic        note_gate,
  output logic [6:0]  note_num,
  output logic        busy
);

  localparam int CW = (TRIG_HOLD > 2) ? $clog2(TRIG_HOLD) : 1;

  typedef enum logic [1:0] {WAIT_STATUS, WAIT_D1, WAIT_D2} p_state_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOW, S_GAP} s_state_e;

  p_state_e  pstate_q, pstate_d;
  logic [7:0] rs_q, rs_d;
  logic       rs_vld_q, rs_vld_d;
  logic [6:0] d1_q, d1_d;
  logic       msg_done;
  logic       chan_ok, note_on_ev, note_off_ev;
  logic [6:0] d2;

  s_state_e  sstate_q, sstate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] cur_note_q, cur_note_d, cur_vel_q, cur_vel_d;
  logic       pend_vld_q, pend_vld_d;
  logic [6:0] pend_note_q, pend_note_d, pend_vel_q, pend_vel_d;
  logic [6:0] vel_q, vel_d, note_q, note_d;
  logic [11:0] dly_q, dly_d;
  logic       gate_q, gate_d, trig_q, trig_d;

  logic [6:0]  fold_n;
  logic [3:0]  semi, shift;
  logic [11:0] base, shifted, dly_calc;

  assign d2 = rx_data[6:0];

`ifdef KP_MIDI_OMNI_EN
  logic unused_chan;
  assign unused_chan = ^{midi_chan, rs_q[3:0]};
  assign chan_ok = 1'b1;
`else
  assign chan_ok = (rs_q[3:0] == midi_chan);
`endif

  assign note_on_ev  = msg_done && chan_ok && (rs_q[7:4] == 4'h9) && (d2 != 7'd0);
  assign note_off_ev = msg_done && chan_ok &&
                       ((rs_q[7:4] == 4'h8) || ((rs_q[7:4] == 4'h9) && (d2 == 7'd0)));

  // Byte parser: running status, realtime passthrough, one/two data-byte messages
  always_comb begin
    pstate_d = pstate_q;
    rs_d     = rs_q;
    rs_vld_d = rs_vld_q;
    d1_d     = d1_q;
    msg_done = 1'b0;
    if (rx_err) begin
      pstate_d = WAIT_STATUS;
      rs_vld_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_data >= 8'hF8) begin
        // realtime bytes leave the parser untouched
      end else if (rx_data >= 8'hF0) begin
        rs_vld_d = 1'b0;
        pstate_d = WAIT_STATUS;
      end else if (rx_data[7]) begin
        rs_d     = rx_data;
        rs_vld_d = 1'b1;
        pstate_d = WAIT_D1;
      end else begin
        case (pstate_q)
          WAIT_D2: begin
            msg_done = 1'b1;
            pstate_d = WAIT_D1;
          end
          default: begin
            if (rs_vld_q) begin
              d1_d = d2;
              // program change / channel pressure complete on their single data byte
              if ((rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD)) pstate_d = WAIT_D1;
              else pstate_d = WAIT_D2;
            end
          end
        endcase
      end
    end
  end

  // Note number to delay-line length: octave-shifted lookup, floored at MIN_DELAY
  always_comb begin
    fold_n = (cur_note_q < 7'd24) ? (7'(cur_note_q % 7'd12) + 7'd24) : cur_note_q;
    semi   = 4'(fold_n % 7'd12);
    shift  = 4'(fold_n / 7'd12) - 4'd2;
    case (semi)
      4'd0:    base = 12'd2935;
      4'd1:    base = 12'd2771;
      4'd2:    base = 12'd2615;
      4'd3:    base = 12'd2468;
      4'd4:    base = 12'd2330;
      4'd5:    base = 12'd2199;
      4'd6:    base = 12'd2076;
      4'd7:    base = 12'd1959;
      4'd8:    base = 12'd1849;
      4'd9:    base = 12'd1745;
      4'd10:   base = 12'd1647;
      default: base = 12'd1555;
    endcase
    shifted  = base >> shift;
    dly_calc = (shifted < 12'(MIN_DELAY)) ? 12'(MIN_DELAY) : shifted;
  end

  // Trigger sequencer, pending slot and output registers
  always_comb begin
    sstate_d    = sstate_q;
    cnt_d       = cnt_q;
    cur_note_d  = cur_note_q;
    cur_vel_d   = cur_vel_q;
    pend_vld_d  = pend_vld_q;
    pend_note_d = pend_note_q;
    pend_vel_d  = pend_vel_q;
    vel_d       = vel_q;
    note_d      = note_q;
    dly_d       = dly_q;
    gate_d      = gate_q;
    trig_d      = (sstate_q != S_LOW);
    case (sstate_q)
      S_IDLE: begin
        if (note_on_ev) begin
          cur_note_d = d1_q;
          cur_vel_d  = d2;
          sstate_d   = S_LOAD;
        end else if (pend_vld_q) begin
          cur_note_d = pend_note_q;
          cur_vel_d  = pend_vel_q;
          pend_vld_d = 1'b0;
          sstate_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d    = '0;
        sstate_d = S_LOW;
      end
      S_LOW: begin
        if (cnt_q == CW'(TRIG_HOLD - 1)) begin
          cnt_d    = '0;
          sstate_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (cnt_q == CW'(TRIG_HOLD - 1)) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            cur_note_d = pend_note_q;
            cur_vel_d  = pend_vel_q;
            pend_vld_d = 1'b0;
            sstate_d   = S_LOAD;
          end else begin
            sstate_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    // a note arriving while the sequencer is occupied overwrites the pending slot
    if (note_on_ev && (sstate_q != S_IDLE)) begin
      pend_vld_d  = 1'b1;
      pend_note_d = d1_q;
      pend_vel_d  = d2;
    end
    if (note_off_ev && pend_vld_q && (pend_note_q == d1_q)) pend_vld_d = 1'b0;
    if (sstate_q == S_LOAD) begin
      vel_d  = cur_vel_q;
      note_d = cur_note_q;
      dly_d  = dly_calc;
      gate_d = 1'b1;
    end else if (note_off_ev && (d1_q == note_q)) begin
      gate_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      pstate_q    <= WAIT_STATUS;
      rs_q        <= 8'h00;
      rs_vld_q    <= 1'b0;
      d1_q        <= 7'd0;
      sstate_q    <= S_IDLE;
      cnt_q       <= '0;
      cur_note_q  <= 7'd60;
      cur_vel_q   <= 7'd0;
      pend_vld_q  <= 1'b0;
      pend_note_q <= 7'd0;
      pend_vel_q  <= 7'd0;
      vel_q       <= 7'd0;
      note_q      <= 7'd60;
      dly_q       <= 12'd366;
      gate_q      <= 1'b0;
      trig_q      <= 1'b1;
    end else begin
      pstate_q    <= pstate_d;
      rs_q        <= rs_d;
      rs_vld_q    <= rs_vld_d;
      d1_q        <= d1_d;
      sstate_q    <= sstate_d;
      cnt_q       <= cnt_d;
      cur_note_q  <= cur_note_d;
      cur_vel_q   <= cur_vel_d;
      pend_vld_q  <= pend_vld_d;
      pend_note_q <= pend_note_d;
      pend_vel_q  <= pend_vel_d;
      vel_q       <= vel_d;
      note_q      <= note_d;
      dly_q       <= dly_d;
      gate_q      <= gate_d;
      trig_q      <= trig_d;
    end
  end

  assign trig         = trig_q;
  assign velocity     = vel_q;
  assign delay_length = dly_q;
  assign note_gate    = gate_q;
  assign note_num     = note_q;
  assign busy         = (sstate_q != S_IDLE) || pend_vld_q;

endmodule
